rx_buf_writer: RTL and testbench
================================

RX_BUF_WRITER -- requirements
Module: rx_buf_writer

Interface
REQ-001 SHALL have ports: sysck  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: rx_data  in  8  received byte from MAC receive path.
REQ-004 SHALL have ports: rx_valid  in  1  rx_data valid this cycle; no back-pressure.
REQ-005 SHALL have ports: rx_sof / rx_eof  in  1 each  qualify first / last byte, both valid only with rx_valid.
REQ-006 SHALL have ports: rx_bad  in  1  frame CRC/symbol error, sampled with rx_eof.
REQ-007 SHALL have ports: ERR_RAM_REC  in  1  receive RAM overrun flag from memory control unit.
REQ-008 SHALL have ports: rec_release  in  1  one-cycle pulse, CPU has consumed pending frame.
REQ-009 SHALL have ports: receive_we  out  1  receive RAM write strobe.
REQ-010 SHALL have ports: int_mem_rec_adr  out  9  receive RAM write address.
REQ-011 SHALL have ports: mem_wdata  out  8  receive RAM write data.
REQ-012 SHALL have ports: rec_OK  out  1  level, one committed frame pending for CPU.
REQ-013 SHALL have ports: rec_base  out  9  start address of pending frame; rec_len  out  10  its byte count.
REQ-014 SHALL have ports: drop_cnt  out  8  saturating count of dropped frames.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, DROP; write pointer wr_ptr (9 bit) and frame base fbase (9 bit) internal.
REQ-016 SHALL, in IDLE, start a frame on rx_valid&rx_sof: write byte at wr_ptr, len<=1, go WRITE; rx_valid without rx_sof ignored.
REQ-017 SHALL register writes: receive_we, int_mem_rec_adr, mem_wdata appear exactly 1 cycle after the accepted rx_valid.
REQ-018 SHALL, in WRITE, write every rx_valid byte at wr_ptr, wr_ptr<=wr_ptr+1 modulo 512 (511 wraps to 0), len<=len+1.
REQ-019 SHALL on rx_valid&rx_eof&!rx_bad in WRITE commit: write the byte, rec_base<=fbase, rec_len<=len+1, fbase<=wr_ptr+1, rec_OK<=1 next cycle, go IDLE.
REQ-020 SHALL on rx_eof&rx_bad: write no byte, wr_ptr<=fbase, drop_cnt+1, go IDLE.
REQ-021 SHALL on ERR_RAM_REC=1 in WRITE: suppress write, wr_ptr<=fbase, drop_cnt+1, go DROP.
REQ-022 SHALL treat a byte that would make len=512 as overflow: handled as REQ-021.
REQ-023 SHALL, in DROP, issue no writes and return to IDLE on rx_valid&rx_eof.
REQ-024 SHALL treat rx_sof during WRITE as abort+restart: drop_cnt+1, wr_ptr<=fbase, byte written at fbase, len<=1.
REQ-025 SHALL, while rec_OK=1, drop any new sof frame (go DROP, drop_cnt+1); only one frame pending.
REQ-026 SHALL clear rec_OK the cycle after rec_release; release and commit in the same cycle: commit wins, rec_OK stays 1.
REQ-027 SHALL saturate drop_cnt at 255; rec_base/rec_len hold until next commit.
REQ-028 SHALL treat rx_sof&rx_eof in the same cycle as a 1-byte frame (rec_len=1).

Reset
REQ-029 SHALL, on reset=0, asynchronously set state IDLE, wr_ptr=fbase=0, receive_we=0, int_mem_rec_adr=0, mem_wdata=0, rec_OK=0, rec_base=0, rec_len=0, drop_cnt=0.
REQ-030 SHALL discard a frame in progress at reset; no write after reset release until a new rx_sof.

Structure
REQ-031 SHALL take RAM depth (512), address width (9), length width (10) and FSM state encodings from the shared MAC package.
REQ-032 SHALL be a single module; the saturating drop counter MAY be sub-module sat_cnt8.

Verification
REQ-033 SHALL cover: reset, 64-byte good frame -> writes at 0..63, rec_OK=1, rec_base=0, rec_len=64.
REQ-034 SHALL cover: frame starting at wr_ptr=500, 20 bytes -> addresses 500..511,0..7, rec_len=20.
REQ-035 SHALL cover: 30-byte frame with rx_bad at eof -> rec_OK=0, drop_cnt=1, next frame starts at same base.
REQ-036 SHALL cover: ERR_RAM_REC at byte 10 -> receive_we low until next sof, drop_cnt=1, wr_ptr rewound.
REQ-037 SHALL cover: second frame while rec_OK=1 -> no writes, drop_cnt+1; rec_release then third frame -> committed.
REQ-038 SHALL cover: 600-byte frame -> drop at byte 512, no rec_OK; reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/rx_buf_writer_pkg.sv
// Shared MAC receive-path constants, types and helpers used by the receive buffer writer.
package rx_buf_writer_pkg;

  localparam int unsigned RamDepth = 512;
  localparam int unsigned AddrW    = 9;
  localparam int unsigned LenW     = 10;
  localparam int unsigned DataW    = 8;
  localparam int unsigned CntW     = 8;

  typedef logic [AddrW-1:0] addr_t;
  typedef logic [LenW-1:0]  len_t;
  typedef logic [DataW-1:0] data_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDrop  = 2'd2
  } rx_state_e;

  // A frame may hold at most RamDepth-1 bytes; the next byte is an overflow.
  localparam len_t MaxLen = len_t'(RamDepth - 1);

  // Address arithmetic wraps naturally at the RAM depth.
  function automatic addr_t addr_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/rx_buf_writer_sat_cnt8.sv
// Eight-bit up-counter that sticks at its maximum value.
module sat_cnt8
  import rx_buf_writer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [CntW-1:0] cnt
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rx_buf_writer.sv
// Writes received MAC frames into a circular receive RAM and hands one committed
// frame at a time to the CPU; bad, overrun or oversized frames are rewound and counted.
module rx_buf_writer
  import rx_buf_writer_pkg::*;
(
  input  logic             sysck,
  input  logic             reset,
  input  logic [DataW-1:0] rx_data,
  input  logic             rx_valid,
  input  logic             rx_sof,
  input  logic             rx_eof,
  input  logic             rx_bad,
  input  logic             ERR_RAM_REC,
  input  logic             rec_release,
  output logic             receive_we,
  output logic [AddrW-1:0] int_mem_rec_adr,
  output logic [DataW-1:0] mem_wdata,
  output logic             rec_OK,
  output logic [AddrW-1:0] rec_base,
  output logic [LenW-1:0]  rec_len,
  output logic [CntW-1:0]  drop_cnt
);

  rx_state_e state_q, state_d;
  addr_t     wr_ptr_q, wr_ptr_d;
  addr_t     fbase_q, fbase_d;
  len_t      len_q, len_d;
  logic      we_q, we_d;
  addr_t     adr_q, adr_d;
  data_t     wdata_q, wdata_d;
  logic      rec_ok_q, rec_ok_d;
  addr_t     rec_base_q, rec_base_d;
  len_t      rec_len_q, rec_len_d;

  // Decoded actions for this cycle.
  logic      wr_go;
  addr_t     wr_addr;
  logic      start;
  logic      commit;
  logic      rewind;
  logic      drop_inc;

  logic      sof, eof;

  assign sof = rx_valid & rx_sof;
  assign eof = rx_valid & rx_eof;

  always_comb begin
    state_d  = state_q;
    wr_go    = 1'b0;
    wr_addr  = wr_ptr_q;
    start    = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    drop_inc = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sof) begin
          if (rec_ok_q) begin
            // Only one frame may be pending; discard the newcomer whole.
            drop_inc = 1'b1;
            if (!rx_eof) state_d = StDrop;
          end else if (rx_eof && rx_bad) begin
            drop_inc = 1'b1;
          end else begin
            wr_go   = 1'b1;
            start   = 1'b1;
            commit  = rx_eof;
            state_d = rx_eof ? StIdle : StWrite;
          end
        end
      end

      StWrite: begin
        if (ERR_RAM_REC) begin
          rewind   = 1'b1;
          drop_inc = 1'b1;
          state_d  = eof ? StIdle : StDrop;
        end else if (sof) begin
          // Abort the partial frame and restart at its base address.
          drop_inc = 1'b1;
          rewind   = 1'b1;
          if (rx_eof && rx_bad) begin
            state_d = StIdle;
          end else begin
            wr_go   = 1'b1;
            wr_addr = fbase_q;
            start   = 1'b1;
            commit  = rx_eof;
            state_d = rx_eof ? StIdle : StWrite;
          end
        end else if (rx_valid) begin
          if (rx_eof && rx_bad) begin
            rewind   = 1'b1;
            drop_inc = 1'b1;
            state_d  = StIdle;
          end else if (len_q == MaxLen) begin
            rewind   = 1'b1;
            drop_inc = 1'b1;
            state_d  = rx_eof ? StIdle : StDrop;
          end else begin
            wr_go  = 1'b1;
            commit = rx_eof;
            if (rx_eof) state_d = StIdle;
          end
        end
      end

      StDrop: begin
        if (eof) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fbase_d    = fbase_q;
    len_d      = len_q;
    we_d       = 1'b0;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rec_ok_d   = rec_ok_q & ~rec_release;
    rec_base_d = rec_base_q;
    rec_len_d  = rec_len_q;

    if (rewind) wr_ptr_d = fbase_q;

    if (wr_go) begin
      we_d     = 1'b1;
      adr_d    = wr_addr;
      wdata_d  = rx_data;
      wr_ptr_d = addr_inc(wr_addr);
      len_d    = start ? len_t'(1) : len_q + len_t'(1);
      if (start) fbase_d = wr_addr;
    end

    // Commit wins over a release arriving in the same cycle.
    if (commit) begin
      rec_base_d = start ? wr_addr : fbase_q;
      rec_len_d  = start ? len_t'(1) : len_q + len_t'(1);
      fbase_d    = addr_inc(wr_addr);
      rec_ok_d   = 1'b1;
    end
  end

  always_ff @(posedge sysck or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      fbase_q    <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      rec_ok_q   <= 1'b0;
      rec_base_q <= '0;
      rec_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fbase_q    <= fbase_d;
      len_q      <= len_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rec_ok_q   <= rec_ok_d;
      rec_base_q <= rec_base_d;
      rec_len_q  <= rec_len_d;
    end
  end

  sat_cnt8 u_drop_cnt (
    .clk   (sysck),
    .rst_n (reset),
    .inc   (drop_inc),
    .cnt   (drop_cnt)
  );

  assign receive_we      = we_q;
  assign int_mem_rec_adr = adr_q;
  assign mem_wdata       = wdata_q;
  assign rec_OK          = rec_ok_q;
  assign rec_base        = rec_base_q;
  assign rec_len         = rec_len_q;

endmodule

// File: tb/tb_rx_buf_writer.sv
// Directed frame sequence with random payloads, checked against a frame-level model.
module tb_rx_buf_writer;

  logic       sysck = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_sof = 1'b0;
  logic       rx_eof = 1'b0;
  logic       rx_bad = 1'b0;
  logic       ERR_RAM_REC = 1'b0;
  logic       rec_release = 1'b0;
  logic       receive_we;
  logic [8:0] int_mem_rec_adr;
  logic [7:0] mem_wdata;
  logic       rec_OK;
  logic [8:0] rec_base;
  logic [9:0] rec_len;
  logic [7:0] drop_cnt;

  rx_buf_writer dut (
    .sysck           (sysck),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_sof          (rx_sof),
    .rx_eof          (rx_eof),
    .rx_bad          (rx_bad),
    .ERR_RAM_REC     (ERR_RAM_REC),
    .rec_release     (rec_release),
    .receive_we      (receive_we),
    .int_mem_rec_adr (int_mem_rec_adr),
    .mem_wdata       (mem_wdata),
    .rec_OK          (rec_OK),
    .rec_base        (rec_base),
    .rec_len         (rec_len),
    .drop_cnt        (drop_cnt)
  );

  always #5 sysck = ~sysck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_we_cyc = -1;
  logic [16:0] got_q[$];

  // Frame-level model state.
  int m_base = 0;
  bit m_ok = 0;
  int m_rbase = 0;
  int m_rlen = 0;
  int m_drop = 0;

  always @(posedge sysck) cyc <= cyc + 1;

  always @(negedge sysck) begin
    if (receive_we === 1'b1) begin
      got_q.push_back({int_mem_rec_adr, mem_wdata});
      if (first_we_cyc < 0) first_we_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sysck); #1;
      rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_bad = 0; ERR_RAM_REC = 0; rec_release = 0;
    end
  endtask

  task automatic drive(input logic [7:0] d, input bit sof, input bit eof, input bit bad,
                       input bit err, input bit rel);
    @(posedge sysck); #1;
    rx_data = d; rx_valid = 1; rx_sof = sof; rx_eof = eof; rx_bad = bad;
    ERR_RAM_REC = err; rec_release = rel;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " rec_OK"}, 32'(rec_OK), 32'(m_ok));
    chk({tag, " rec_base"}, 32'(rec_base), m_rbase);
    chk({tag, " rec_len"}, 32'(rec_len), m_rlen);
    chk({tag, " drop_cnt"}, 32'(drop_cnt), m_drop);
  endtask

  task automatic release_frame(input string tag);
    @(posedge sysck); #1; rec_release = 1;
    idle(2);
    m_ok = 0;
    chk({tag, " released"}, 32'(rec_OK), 32'(m_ok));
  endtask

  task automatic send_frame(input string tag, input int n, input bit bad, input int err_at,
                            input bit rel_eof);
    logic [7:0] fd[$];
    logic [7:0] d;
    int nw;
    int sof_cyc;
    bit commit;
    got_q.delete();
    first_we_cyc = -1;
    sof_cyc = 0;
    // Stray bytes outside a frame must be ignored.
    if ($urandom_range(0, 1) == 1) drive(8'($urandom), 0, 0, 0, 0, 0);
    for (int i = 1; i <= n; i++) begin
      d = 8'($urandom);
      fd.push_back(d);
      drive(d, i == 1, i == n, bad && (i == n), i == err_at, rel_eof && (i == n));
      if (i == 1) sof_cyc = cyc;
      if (i < n && $urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    commit = 0;
    if (m_ok) nw = 0;
    else if (err_at >= 2 && err_at <= n && err_at <= 511) nw = err_at - 1;
    else if (n > 511) nw = 511;
    else if (bad) nw = n - 1;
    else begin nw = n; commit = 1; end

    chk({tag, " nwrites"}, got_q.size(), nw);
    for (int i = 0; i < nw && i < got_q.size(); i++)
      chk({tag, " write"}, 32'(got_q[i]), 32'({9'((m_base + i) % 512), fd[i]}));
    if (nw > 0) chk({tag, " latency"}, first_we_cyc - sof_cyc, 1);

    if (commit) begin
      m_rbase = m_base;
      m_rlen = n;
      m_base = (m_base + n) % 512;
      m_ok = 1;
    end else begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (rel_eof) m_ok = 0;
    end
    check_regs(tag);
  endtask

  initial begin
    #22;
    chk("rst receive_we", 32'(receive_we), 0);
    chk("rst adr", 32'(int_mem_rec_adr), 0);
    chk("rst wdata", 32'(mem_wdata), 0);
    check_regs("rst");
    #3 reset = 1;
    idle(2);

    send_frame("good64", 64, 0, 0, 0);
    release_frame("good64");
    send_frame("bad30", 30, 1, 0, 0);
    send_frame("same_base", 10, 0, 0, 0);
    release_frame("same_base");
    send_frame("fill", 426, 0, 0, 0);
    release_frame("fill");
    send_frame("wrap20", 20, 0, 0, 0);
    release_frame("wrap20");
    send_frame("ramerr", 40, 0, 10, 0);
    send_frame("after_err", 15, 0, 0, 0);
    send_frame("pending", 12, 0, 0, 0);
    release_frame("pending");
    send_frame("third", 25, 0, 0, 0);
    release_frame("third");
    send_frame("rel_commit", 5, 0, 0, 1);
    release_frame("rel_commit");
    send_frame("over600", 600, 0, 0, 0);
    send_frame("one_byte", 1, 0, 0, 0);
    release_frame("one_byte");
    for (int k = 0; k < 260; k++) send_frame("sat", 1, 1, 0, 0);

    // Reset in the middle of a frame.
    drive(8'($urandom), 1, 0, 0, 0, 0);
    for (int i = 0; i < 19; i++) drive(8'($urandom), 0, 0, 0, 0, 0);
    idle(1);
    #2 reset = 0;
    #1;
    chk("midrst receive_we", 32'(receive_we), 0);
    chk("midrst adr", 32'(int_mem_rec_adr), 0);
    chk("midrst wdata", 32'(mem_wdata), 0);
    m_base = 0; m_ok = 0; m_rbase = 0; m_rlen = 0; m_drop = 0;
    check_regs("midrst");
    got_q.delete();
    idle(2);
    #2 reset = 1;
    for (int i = 0; i < 10; i++) drive(8'($urandom), 0, i == 9, 0, 0, 0);
    idle(3);
    chk("post_rst no writes", got_q.size(), 0);
    send_frame("post_rst", 8, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
